// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (F_RUN issues reads, F_HALT stops issue)
//   WORD_W/ADDR_W : instruction word and word-address widths
//   *_DEF         : default values for the fetch_unit parameters
package fetch_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic {
        F_RUN  = 1'b0,
        F_HALT = 1'b1
    } fetch_state_e;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [3:0]        HALT_OP_DEF   = 4'hF;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding an instruction word and its PC+1
// when a memory response arrives while decode is stalled.
//   clk, rst       : clock, asynchronous active-low reset (clears valid only)
//   load           : capture load_instr/load_pc
//   drain          : entry consumed by IF/ID this cycle
//   clear          : discard entry (redirect)
//   valid          : entry present
//   instr, pc      : stored instruction and its PC+1
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc,
    output logic        valid,
    output logic [15:0] instr,
    output logic [15:0] pc
);

    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear || drain) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is only meaningful while valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, issues word reads to a
// synchronous instruction memory and drives the IF/ID register for decode.
//   clk, rst            : clock, asynchronous active-low reset
//   hazard              : decode stall, hold IF/ID and PC
//   PC_update           : leave HALT and resume fetch
//   redirect/redirect_pc: execute-stage control transfer and its target
//   imem_re/imem_addr   : read request (address is pc_q)
//   imem_rdata          : read data, one cycle after an issued read
//   instr_out/PC_out    : IF/ID instruction and its address + 1
//   instr_valid         : IF/ID holds a real instruction
//   halted              : FSM is in F_HALT
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [3:0]  HALT_OP   = HALT_OP_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        PC_update,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_re,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        instr_valid,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q, inflight_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;

    logic         issue;
    logic         load_ifid;
    logic [15:0]  load_instr;
    logic [15:0]  load_pc;
    logic         skid_load, skid_drain, skid_clear;
    logic         skid_valid;
    logic [15:0]  skid_instr, skid_pc;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (fetch_pc_q + 16'd1),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // A full skid blocks issue so the buffer never has to hold two entries.
    assign issue     = (state_q == F_RUN) && !hazard && !skid_valid && !redirect;
    assign imem_re   = issue;
    assign imem_addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        load_ifid  = 1'b0;
        load_instr = imem_rdata;
        load_pc    = fetch_pc_q + 16'd1;

        if (redirect) begin
            // Redirect beats stall and halt: flush everything and retarget.
            state_d    = F_RUN;
            pc_d       = redirect_pc;
            skid_clear = 1'b1;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d = pc_q;
                pc_d       = pc_q + 16'd1;
                inflight_d = 1'b1;
            end
            if (state_q == F_HALT && PC_update) begin
                state_d = F_RUN;
            end

            if (inflight_q) begin
                if (hazard) skid_load = 1'b1;
                else        load_ifid = 1'b1;
            end else if (skid_valid && !hazard) begin
                skid_drain = 1'b1;
                load_ifid  = 1'b1;
                load_instr = skid_instr;
                load_pc    = skid_pc;
            end else if (!hazard) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end

            if (load_ifid) begin
                instr_d  = load_instr;
                pc_out_d = load_pc;
                valid_d  = 1'b1;
                // HLT entering IF/ID stops fetch; the read issued alongside
                // it is dropped and the PC rewinds to just past the HLT.
                if (load_instr[15:12] == HALT_OP) begin
                    state_d    = F_HALT;
                    pc_d       = load_pc;
                    inflight_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= F_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_out_q   <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

    // Only consulted while inflight_q is set.
    always_ff @(posedge clk) begin
        fetch_pc_q <= fetch_pc_d;
    end

    assign instr_out   = instr_q;
    assign PC_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == F_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        PC_update;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_re;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        instr_valid;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:65535];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .hazard      (hazard),
        .PC_update   (PC_update),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_re     (imem_re),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .PC_out      (PC_out),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read.
    always @(posedge clk) begin
        if (imem_re) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc1, input logic v);
        check({tag, ".instr"}, {16'h0, instr_out}, {16'h0, ins});
        check({tag, ".pc"},    {16'h0, PC_out},    {16'h0, pc1});
        check({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
    endtask

    initial begin
        // Default word at address i is 0x2000 | i[11:0]; a few overrides.
        for (int i = 0; i < 65536; i++) mem[i] = {4'h2, 12'(i)};
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;
        mem[5] = 16'hF000;

        rst = 1'b0; hazard = 1'b0; PC_update = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000;
        step(); step();

        // Reset state
        check("rst.instr",  {16'h0, instr_out}, 32'h0);
        check("rst.pc",     {16'h0, PC_out}, 32'h0);
        check("rst.valid",  {31'h0, instr_valid}, 32'h0);
        check("rst.halted", {31'h0, halted}, 32'h0);
        check("rst.addr",   {16'h0, imem_addr}, 32'h0);

        // Sequential stream after release
        rst = 1'b1;
        step();                                   // edge 0: read of 0 issued
        check("e0.valid", {31'h0, instr_valid}, 32'h0);
        check("e0.addr",  {16'h0, imem_addr}, 32'h1);
        step(); check_ifid("e1", 16'h1111, 16'h0001, 1'b1);
        step(); check_ifid("e2", 16'h2222, 16'h0002, 1'b1);
        step(); check_ifid("e3", 16'h3333, 16'h0003, 1'b1);

        // Hazard for 3 cycles with read of addr 3 in flight
        hazard = 1'b1;
        #1 check("hz.re", {31'h0, imem_re}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(); check_ifid("hz.hold", 16'h3333, 16'h0003, 1'b1);
        end
        hazard = 1'b0;
        step(); check_ifid("hz.drain", 16'h4444, 16'h0004, 1'b1);
        check("hz.addr", {16'h0, imem_addr}, 32'h4);
        step(); check("hz.bubble", {31'h0, instr_valid}, 32'h0);
        step(); check_ifid("hz.next", 16'h2004, 16'h0005, 1'b1);

        // Redirect to 0x40 during a hazard (read of HLT at 5 in flight)
        redirect = 1'b1; redirect_pc = 16'h0040; hazard = 1'b1;
        step();
        check_ifid("rd.bub", 16'h0000, 16'h0005, 1'b0);
        check("rd.addr", {16'h0, imem_addr}, 32'h40);
        check("rd.halted", {31'h0, halted}, 32'h0);
        redirect = 1'b0; hazard = 1'b0;
        #1 check("rd.re", {31'h0, imem_re}, 32'h1);
        step(); check("rd.gap", {31'h0, instr_valid}, 32'h0);
        step(); check_ifid("rd.tgt", 16'h2040, 16'h0041, 1'b1);

        // HLT at address 5
        redirect = 1'b1; redirect_pc = 16'h0004;
        step();
        redirect = 1'b0;
        step();
        step(); check_ifid("hl.pre", 16'h2004, 16'h0005, 1'b1);
        step(); check_ifid("hl.hlt", 16'hF000, 16'h0006, 1'b1);
        check("hl.halted", {31'h0, halted}, 32'h1);
        check("hl.re",     {31'h0, imem_re}, 32'h0);
        check("hl.addr",   {16'h0, imem_addr}, 32'h6);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hl.idle.valid", {31'h0, instr_valid}, 32'h0);
            check("hl.idle.re",    {31'h0, imem_re}, 32'h0);
            check("hl.idle.halt",  {31'h0, halted}, 32'h1);
        end
        PC_update = 1'b1;
        step();
        PC_update = 1'b0;
        #1;
        check("hl.resume.halt", {31'h0, halted}, 32'h0);
        check("hl.resume.re",   {31'h0, imem_re}, 32'h1);
        check("hl.resume.addr", {16'h0, imem_addr}, 32'h6);
        step();
        step(); check_ifid("hl.after", 16'h2006, 16'h0007, 1'b1);

        // PC wrap at 0xFFFF
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        check("wr.addr0", {16'h0, imem_addr}, 32'hFFFF);
        step(); check("wr.addr1", {16'h0, imem_addr}, 32'h0);
        step(); check_ifid("wr.top", 16'h2FFF, 16'h0000, 1'b1);
        step(); check_ifid("wr.zero", 16'h1111, 16'h0001, 1'b1);

        // Reset mid-stream with skid full
        hazard = 1'b1;
        step(); check_ifid("mr.hold", 16'h1111, 16'h0001, 1'b1);
        rst = 1'b0;
        #1;
        check_ifid("mr.rst", 16'h0000, 16'h0000, 1'b0);
        check("mr.halted", {31'h0, halted}, 32'h0);
        check("mr.addr",   {16'h0, imem_addr}, 32'h0);
        hazard = 1'b0;
        #1 rst = 1'b1;
        step();
        check("mr.e0.valid", {31'h0, instr_valid}, 32'h0);
        check("mr.e0.addr",  {16'h0, imem_addr}, 32'h1);
        step(); check_ifid("mr.e1", 16'h1111, 16'h0001, 1'b1);
        step(); check_ifid("mr.e2", 16'h2222, 16'h0002, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
